// File: rtl/chinpo_pkg.sv
// Shared CHINPO constants: interrupt-controller states, vector table defaults,
// control-unit state numbers and small priority/vector helpers.
package chinpo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } int_state_e;

   localparam logic [15:0] INT_BASE_DEFAULT   = 16'h0F00;
   localparam logic [15:0] VEC_STRIDE_DEFAULT = 16'h0010;
   localparam int unsigned IRQ_LINES          = 4;

   // Control-unit state numbers; CU_INTERRUPT is where IntAck originates.
   localparam logic [3:0] CU_FETCH     = 4'd0;
   localparam logic [3:0] CU_DECODE    = 4'd1;
   localparam logic [3:0] CU_EXECUTE   = 4'd2;
   localparam logic [3:0] CU_MEMORY    = 4'd3;
   localparam logic [3:0] CU_WRITEBACK = 4'd4;
   localparam logic [3:0] CU_INTERRUPT = 4'd5;
   localparam logic [1:0] PC_SEL_INT   = 2'd3;

   function automatic logic [1:0] lowest_index(input logic [3:0] req);
      logic [1:0] idx;
      casez (req)
         4'b???1: idx = 2'd0;
         4'b??10: idx = 2'd1;
         4'b?100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [15:0] handler_vector(input logic [15:0] base,
                                                  input logic [15:0] stride,
                                                  input logic [1:0]  id);
      logic [15:0] id_ext;
      id_ext = {14'd0, id};
      return base + (id_ext * stride);
   endfunction

endpackage

// File: rtl/chinpo_irq_sync.sv
// Two-flop synchronizer plus history flop per line; flags one-cycle rising edges.
module chinpo_irq_sync
   import chinpo_pkg::*;
#(
   parameter int WIDTH = IRQ_LINES
)(
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] irq,
   output logic [WIDTH-1:0] irq_edge
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;
   logic [WIDTH-1:0] hist_r;

   // Synchronizer chain and history; history resets low so a line held high
   // across reset release still yields one edge.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         meta_r <= '0;
         sync_r <= '0;
         hist_r <= '0;
      end else begin
         meta_r <= irq;
         sync_r <= meta_r;
         hist_r <= sync_r;
      end
   end

   assign irq_edge = sync_r & ~hist_r;

endmodule

// File: rtl/chinpo_int_ctrl.sv
// Four-line vectored interrupt controller: latches edges into Pending, picks the
// lowest eligible line and handshakes with the control unit via Int/IntAck/IntReturn.
module chinpo_int_ctrl
   import chinpo_pkg::*;
#(
   parameter logic [15:0] INT_BASE   = INT_BASE_DEFAULT,
   parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
)(
   input  logic        CLK,
   input  logic        Reset_n,
   input  logic [3:0]  IrqIn,
   input  logic        MaskWrite,
   input  logic [3:0]  MaskData,
   input  logic        IntAck,
   input  logic        IntReturn,
   output logic        Int,
   output logic [15:0] IntVector,
   output logic [1:0]  IntId,
   output logic        InService,
   output logic [3:0]  Pending
);

   int_state_e state_r;
   logic [3:0] mask_r;
   logic [3:0] pending_r;
   logic [3:0] edge_s;
   logic [3:0] eligible_s;
   logic [3:0] ack_clr_s;
   logic [1:0] winner_s;
   logic       ack_take_s;

   chinpo_irq_sync #(.WIDTH(4)) u_sync (
      .CLK      (CLK),
      .Reset_n  (Reset_n),
      .irq      (IrqIn),
      .irq_edge (edge_s)
   );

   // Priority selection and acknowledge-clear decode.
   always_comb begin
      eligible_s = pending_r & mask_r;
      winner_s   = lowest_index(eligible_s);
      ack_take_s = (state_r == ST_REQ) && IntAck;
      ack_clr_s  = 4'b0000;
      if (ack_take_s) begin
         ack_clr_s = 4'b0001 << IntId;
      end else begin
         ack_clr_s = 4'b0000;
      end
   end

   // Enable mask register.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         mask_r <= 4'b0000;
      end else if (MaskWrite) begin
         mask_r <= MaskData;
      end else begin
         mask_r <= mask_r;
      end
   end

   // Pending latch; a fresh edge overrides a same-cycle acknowledge clear.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         pending_r <= 4'b0000;
      end else begin
         pending_r <= (pending_r & ~ack_clr_s) | edge_s;
      end
   end

   assign Pending = pending_r;

   // Handshake FSM with registered Int/InService/IntId/IntVector.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r   <= ST_IDLE;
         Int       <= 1'b0;
         InService <= 1'b0;
         IntId     <= 2'd0;
         IntVector <= INT_BASE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|eligible_s) begin
                  state_r   <= ST_REQ;
                  Int       <= 1'b1;
                  IntId     <= winner_s;
                  IntVector <= handler_vector(INT_BASE, VEC_STRIDE, winner_s);
               end
            end
            ST_REQ: begin
               if (IntAck) begin
                  state_r   <= ST_SERVICE;
                  Int       <= 1'b0;
                  InService <= 1'b1;
               end
            end
            ST_SERVICE: begin
               if (IntReturn) begin
                  state_r   <= ST_IDLE;
                  InService <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               Int       <= 1'b0;
               InService <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chinpo_int_ctrl.sv
// Directed self-checking bench for chinpo_int_ctrl.
module tb_chinpo_int_ctrl;

   logic        CLK;
   logic        Reset_n;
   logic [3:0]  IrqIn;
   logic        MaskWrite;
   logic [3:0]  MaskData;
   logic        IntAck;
   logic        IntReturn;
   logic        Int;
   logic [15:0] IntVector;
   logic [1:0]  IntId;
   logic        InService;
   logic [3:0]  Pending;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   chinpo_int_ctrl dut (
      .CLK       (CLK),
      .Reset_n   (Reset_n),
      .IrqIn     (IrqIn),
      .MaskWrite (MaskWrite),
      .MaskData  (MaskData),
      .IntAck    (IntAck),
      .IntReturn (IntReturn),
      .Int       (Int),
      .IntVector (IntVector),
      .IntId     (IntId),
      .InService (InService),
      .Pending   (Pending)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset_n = 1'b0; IrqIn = 4'b0000; MaskWrite = 1'b0; MaskData = 4'b0000;
      IntAck = 1'b0; IntReturn = 1'b0;
      tick(); tick(); tick();
      check("rst_int", 16'(Int), 16'd0);
      check("rst_insvc", 16'(InService), 16'd0);
      check("rst_id", 16'(IntId), 16'd0);
      check("rst_vec", IntVector, 16'h0F00);
      check("rst_pend", 16'(Pending), 16'd0);
      Reset_n = 1'b1;

      // Single line 0, latency t0 -> t2 Pending -> t3 Int
      MaskWrite = 1'b1; MaskData = 4'b0001; tick(); MaskWrite = 1'b0;
      IrqIn = 4'b0001;
      tick(); tick();
      check("t1_pend", 16'(Pending), 16'd0);
      tick();
      check("t2_pend", 16'(Pending), 16'h0001);
      check("t2_int", 16'(Int), 16'd0);
      tick();
      check("t3_int", 16'(Int), 16'd1);
      check("t3_id", 16'(IntId), 16'd0);
      check("t3_vec", IntVector, 16'h0F00);
      IntAck = 1'b1; tick(); IntAck = 1'b0;
      check("ack_insvc", 16'(InService), 16'd1);
      check("ack_int", 16'(Int), 16'd0);
      check("ack_pend", 16'(Pending), 16'd0);
      IntReturn = 1'b1; tick(); IntReturn = 1'b0;
      check("ret_insvc", 16'(InService), 16'd0);

      // Lines 3 and 1 together: line 1 first, then line 3
      MaskWrite = 1'b1; MaskData = 4'b1111; tick(); MaskWrite = 1'b0;
      IrqIn = 4'b1011;
      tick(); tick(); tick();
      check("p2_pend", 16'(Pending), 16'h000A);
      tick();
      check("p2_int", 16'(Int), 16'd1);
      check("p2_id", 16'(IntId), 16'd1);
      check("p2_vec", IntVector, 16'h0F10);
      IntReturn = 1'b1; tick(); IntReturn = 1'b0;
      check("ret_ign_int", 16'(Int), 16'd1);
      check("ret_ign_id", 16'(IntId), 16'd1);
      IntAck = 1'b1; tick(); IntAck = 1'b0;
      check("p2_ack_pend", 16'(Pending), 16'h0008);
      IntReturn = 1'b1; tick(); IntReturn = 1'b0;
      check("p2_idle_int", 16'(Int), 16'd0);
      tick();
      check("p2b_int", 16'(Int), 16'd1);
      check("p2b_id", 16'(IntId), 16'd3);
      check("p2b_vec", IntVector, 16'h0F30);
      IntAck = 1'b1; tick(); IntAck = 1'b0;
      IntReturn = 1'b1; tick(); IntReturn = 1'b0;
      IntAck = 1'b1; tick(); IntAck = 1'b0;
      check("ack_ign_insvc", 16'(InService), 16'd0);
      check("ack_ign_int", 16'(Int), 16'd0);
      IrqIn = 4'b0000; tick(); tick(); tick();

      // Masked request, then enabled by MaskWrite
      MaskWrite = 1'b1; MaskData = 4'b0000; tick(); MaskWrite = 1'b0;
      IrqIn = 4'b0100;
      tick(); tick(); tick(); tick();
      check("m0_pend", 16'(Pending), 16'h0004);
      check("m0_int", 16'(Int), 16'd0);
      MaskWrite = 1'b1; MaskData = 4'b0100; tick(); MaskWrite = 1'b0;
      check("m1_int_lo", 16'(Int), 16'd0);
      tick();
      check("m1_int", 16'(Int), 16'd1);
      check("m1_id", 16'(IntId), 16'd2);
      check("m1_vec", IntVector, 16'h0F20);

      // Higher-priority line becomes eligible while in REQ: selection holds
      MaskWrite = 1'b1; MaskData = 4'b0101; IrqIn = 4'b0101; tick(); MaskWrite = 1'b0;
      tick(); tick(); tick();
      check("hold_pend", 16'(Pending), 16'h0005);
      check("hold_int", 16'(Int), 16'd1);
      check("hold_id", 16'(IntId), 16'd2);
      check("hold_vec", IntVector, 16'h0F20);

      // IntAck coincident with a new edge on line 2: set wins
      IrqIn = 4'b0001; tick(); tick(); tick();
      IrqIn = 4'b0101; tick(); tick();
      IntAck = 1'b1; tick(); IntAck = 1'b0;
      check("race_insvc", 16'(InService), 16'd1);
      check("race_int", 16'(Int), 16'd0);
      check("race_pend", 16'(Pending), 16'h0005);
      IntReturn = 1'b1; tick(); IntReturn = 1'b0;
      check("race_idle", 16'(Int), 16'd0);
      tick();
      check("race_id0", 16'(IntId), 16'd0);
      check("race_vec0", IntVector, 16'h0F00);
      IntAck = 1'b1; tick(); IntAck = 1'b0;
      check("race_pend2", 16'(Pending), 16'h0004);
      IntReturn = 1'b1; tick(); IntReturn = 1'b0;
      tick();
      check("race_id2", 16'(IntId), 16'd2);
      IntAck = 1'b1; tick(); IntAck = 1'b0;
      check("svc_insvc", 16'(InService), 16'd1);

      // Asynchronous reset mid-SERVICE, line 0 held high across release
      Reset_n = 1'b0; #1;
      check("ar_insvc", 16'(InService), 16'd0);
      check("ar_int", 16'(Int), 16'd0);
      check("ar_pend", 16'(Pending), 16'd0);
      check("ar_id", 16'(IntId), 16'd0);
      check("ar_vec", IntVector, 16'h0F00);
      IrqIn = 4'b0001;
      tick(); tick(); tick();
      Reset_n = 1'b1;
      MaskWrite = 1'b1; MaskData = 4'b0001; tick(); MaskWrite = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (Int) begin
            pulses++;
            IntAck = 1'b1; tick(); IntAck = 1'b0;
            IntReturn = 1'b1; tick(); IntReturn = 1'b0;
         end
      end
      check("held_pulses", 16'(pulses), 16'd1);
      check("held_pend", 16'(Pending), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chinpo_int_ctrl.md
CHINPO_INT_CTRL -- requirements
Module: chinpo_int_ctrl

Interface
REQ-001 Parameter INT_BASE, default 16'h0F00, is the base address of the handler vector table.
REQ-002 Parameter VEC_STRIDE, default 16'h0010, is the address distance between consecutive handler entries.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 IrqIn  input  4  asynchronous external request lines; a rising edge raises a request.
REQ-006 MaskWrite  input  1  one-cycle strobe that loads MaskData into the enable mask.
REQ-007 MaskData  input  4  new enable mask; bit k = 1 enables line k.
REQ-008 IntAck  input  1  high for one cycle while the control unit is in its Interrupt state (its MemData output).
REQ-009 IntReturn  input  1  one-cycle strobe marking the end of a handler.
REQ-010 Int  output  1  registered interrupt request to the control unit.
REQ-011 IntVector  output  16  handler address for the selected line, used when PcIn = 3.
REQ-012 IntId  output  2  index of the selected or in-service line.
REQ-013 InService  output  1  high while a handler runs.
REQ-014 Pending  output  4  latched request bits, before masking.

Function
REQ-015 Each IrqIn bit SHALL pass through a 2-flop synchronizer followed by a history flop.
  - edge_k = sync2_k & ~hist_k.
REQ-016 An edge sampled at clock edge t0 SHALL set Pending[k] at edge t2.
REQ-017 Pending[k] SHALL stay set until line k is acknowledged.
REQ-018 Eligible requests are Pending & mask; the lowest eligible index SHALL win (line 0 is highest priority).
REQ-019 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-020 IDLE -> REQ SHALL occur at the first edge where any request is eligible.
  - On that edge, IntId and IntVector latch the winner.
  - IntVector = INT_BASE + IntId*VEC_STRIDE, modulo 2^16.
REQ-021 Int SHALL be 1 exactly while in REQ; Int first rises at t3 after the input edge.
REQ-022 REQ -> SERVICE SHALL occur on IntAck.
  - Pending[IntId] clears on the same edge.
  - InService is 1 exactly while in SERVICE.
REQ-023 In REQ, IntId, IntVector and Int SHALL hold even if mask changes or a higher-priority line becomes eligible.
REQ-024 SERVICE -> IDLE SHALL occur on IntReturn; no nesting, so new requests only accumulate in Pending.
REQ-025 If IntAck and a new edge arrive on the same line in the same cycle, the set SHALL win and Pending[k] stays 1.
REQ-026 IntAck outside REQ and IntReturn outside SERVICE SHALL be ignored.
REQ-027 MaskWrite SHALL update the mask at the next edge in any state; it never alters Pending.
REQ-028 If IntReturn and an eligible request arrive in the same cycle, the FSM SHALL go SERVICE -> IDLE and then -> REQ on the next edge (minimum 1 IDLE cycle).

Reset
REQ-029 While Reset_n = 0, the block SHALL hold:
  - state IDLE;
  - mask, Pending, synchronizer and history flops all 0;
  - Int = 0, InService = 0, IntId = 0, IntVector = INT_BASE.
REQ-030 Reset asserted mid-REQ or mid-SERVICE SHALL drop Int and InService immediately (asynchronously); requests in flight are lost.
REQ-031 The history flops reset to 0, so a line held high through reset release SHALL register exactly one request.

Structure
REQ-032 State encodings, INT_BASE and VEC_STRIDE defaults SHALL live in the shared CHINPO constants package, alongside the control-unit state numbers.
REQ-033 The synchronizer plus edge detector SHALL be one sub-module, chinpo_irq_sync, instantiated once with width 4.

Verification
REQ-034 Mask 4'b0001 written, IrqIn[0] rises at t0 -> Pending[0] = 1 at t2, Int = 1 at t3, IntVector = 16'h0F00, IntId = 0.
REQ-035 Mask 4'b1111, IrqIn[3] and IrqIn[1] rise together -> IntId = 1, IntVector = 16'h0F10. After IntAck and IntReturn -> second Int with IntId = 3, IntVector = 16'h0F30.
REQ-036 Mask 4'b0000, IrqIn[2] rises -> Pending[2] = 1, Int stays 0. Write mask 4'b0100 -> Int = 1 one cycle after MaskWrite.
REQ-037 In REQ for line 2, assert IntAck in the same cycle as a new IrqIn[2] edge -> SERVICE entered and Pending[2] remains 1.
REQ-038 Assert Reset_n = 0 mid-SERVICE -> Int = 0, InService = 0, Pending = 0 immediately. Hold IrqIn[0] high through release with mask 4'b0001 -> exactly one Int pulse.
